// File: rtl/pcf8575_pkg.sv
// rtl/pcf8575_pkg.sv - shared scan states, pin map and address nibble for the PCF8575 blocks
package pcf8575_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_COMPARE,
    ST_EMIT
  } scan_state_t;

  localparam int COL_LSB = 0;
  localparam int ROW_LSB = 8;

  localparam logic [3:0] PCF_ADDR_NIBBLE = 4'b0100;

  // Active-low column drive: only the selected column is pulled low.
  function automatic logic [3:0] col_drive(input logic [1:0] col);
    logic [3:0] pat;
    pat      = 4'hF;
    pat[col] = 1'b0;
    return pat;
  endfunction

endpackage

// File: rtl/pcf8575_lowest_diff.sv
// rtl/pcf8575_lowest_diff.sv - priority encoder for the lowest bit where candidate and key_state differ
module pcf8575_lowest_diff
  import pcf8575_pkg::*;
(
  input  logic [15:0] candidate,
  input  logic [15:0] key_state,
  output logic        found,
  output logic [3:0]  index
);

  logic [15:0] diff;

  assign diff = candidate ^ key_state;

  // Walk from the top so the lowest differing bit is the last one written.
  always_comb begin
    found = |diff;
    index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) index = 4'(i);
    end
  end

endmodule

// File: rtl/pcf8575_keypad_scan.sv
// rtl/pcf8575_keypad_scan.sv - 4x4 keypad scanner and debouncer behind a PCF8575 expander
module pcf8575_keypad_scan
  import pcf8575_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 256,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic [7:0]  aux_out,
  output logic [15:0] pcf_wdata,
  input  logic [15:0] pcf_rdata,
  output logic [15:0] key_state,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_press,
  output logic        scan_busy
);

  localparam int            SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    DEB         = 4'(DEBOUNCE_SCANS);

  scan_state_t   state;
  logic [1:0]    col;
  logic [SW-1:0] settle_cnt;
  logic [15:0]   snapshot;
  logic [15:0]   candidate;
  logic [3:0]    stable_cnt;
  logic [3:0]    stable_next;
  logic          diff_found;
  logic [3:0]    diff_index;
  logic          drive_active;

  pcf8575_lowest_diff u_lowest_diff (
    .candidate (candidate),
    .key_state (key_state),
    .found     (diff_found),
    .index     (diff_index)
  );

  assign drive_active = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign scan_busy    = (state != ST_IDLE);

  always_comb begin
    pcf_wdata                = 16'hFFFF;
    pcf_wdata[15:12]         = aux_out[7:4];
    pcf_wdata[7:4]           = aux_out[3:0];
    pcf_wdata[ROW_LSB +: 4]  = 4'hF;
    pcf_wdata[COL_LSB +: 4]  = drive_active ? col_drive(col) : 4'hF;
  end

  // Stability count after this scan's snapshot is folded into the candidate.
  always_comb begin
    if (snapshot != candidate)  stable_next = 4'd1;
    else if (stable_cnt >= DEB) stable_next = DEB;
    else                        stable_next = stable_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      col        <= 2'd0;
      settle_cnt <= '0;
      snapshot   <= 16'h0000;
      candidate  <= 16'h0000;
      stable_cnt <= 4'd0;
      key_state  <= 16'h0000;
      key_valid  <= 1'b0;
      key_code   <= 4'd0;
      key_press  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (scan_en) begin
            col   <= 2'd0;
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= ST_SAMPLE;
          else                           settle_cnt <= settle_cnt + SW'(1);
        end
        ST_SAMPLE: begin
          snapshot[{col, 2'b00} +: 4] <= ~pcf_rdata[ROW_LSB +: 4];
          if (col == 2'd3) begin
            state <= ST_COMPARE;
          end else begin
            col   <= col + 2'd1;
            state <= ST_DRIVE;
          end
        end
        ST_COMPARE: begin
          candidate  <= snapshot;
          stable_cnt <= stable_next;
          if (stable_next == DEB && snapshot != key_state) begin
            state <= ST_EMIT;
          end else begin
            col   <= 2'd0;
            state <= scan_en ? ST_DRIVE : ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (diff_found) begin
            key_valid             <= 1'b1;
            key_code              <= diff_index;
            key_press             <= candidate[diff_index];
            key_state[diff_index] <= candidate[diff_index];
          end else begin
            col   <= 2'd0;
            state <= scan_en ? ST_DRIVE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
